// File: rtl/lcd_text_engine.sv
// HD44780-compatible 8-bit text engine: character buffer, bus tick divider,
// power-on init and a row-addressed refresh sequencer for ROWS x COLS displays.
module lcd_text_engine #(
    parameter int CLK_DIV     = 16,
    parameter int ROWS        = 2,
    parameter int COLS        = 16,
    parameter int POWER_TICKS = 4000,
    parameter int CMD_TICKS   = 16,
    parameter int CLEAR_TICKS = 600,
    parameter int AUTO_TICKS  = 0
) (
    input  logic       clk,
    input  logic       sysrst,
    input  logic       update,
    input  logic       wren,
    input  logic [7:0] addressDsp,
    input  logic [7:0] dataDsp,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);
    localparam int CELLS     = ROWS * COLS;
    localparam int BAW       = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int DW        = $clog2(CLK_DIV);
    localparam int AUW       = $clog2(AUTO_TICKS + 1) + 1;
    localparam int AUTO_LAST = (AUTO_TICKS > 0) ? AUTO_TICKS - 1 : 0;
    localparam logic [7:0] BASE2 = 8'(COLS);
    localparam logic [7:0] BASE3 = 8'(64 + COLS);

    typedef enum logic [2:0] {ST_POWER, ST_INIT, ST_IDLE, ST_ROWADDR, ST_CHARS} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_WAIT} phase_t;

    state_t           state_r, state_n;
    phase_t           phase_r, phase_n;
    logic [15:0]      wait_cnt_r, wait_n, wait_last_s;
    logic [1:0]       init_idx_r, init_idx_n, row_r, row_n;
    logic [5:0]       col_r, col_n;
    logic [AUW-1:0]   auto_cnt_r, auto_n;
    logic [DW-1:0]    div_cnt_r;
    logic [8:0]       sweep_cnt_r, rd_addr_s;
    logic             pending_r, pending_n, busy_r, busy_n, init_done_r, init_done_n;
    logic             lcd_rs_r, rs_n, lcd_e_r, e_n;
    logic [7:0]       lcd_data_r, data_n, cmd_byte_s, base_s, rd_data_r;
    logic             tick_s, sweeping_s, wr_en_s, auto_hit_s, req_s, cmd_state_s;
    logic [BAW-1:0]   wr_addr_s;
    logic [7:0]       wr_data_s;
    logic [7:0]       mem_r [0:(1 << BAW) - 1];

    assign tick_s      = (div_cnt_r == DW'(CLK_DIV - 1));
    assign sweeping_s  = (sweep_cnt_r < 9'(CELLS));
    assign wr_en_s     = sweeping_s | (wren & ({1'b0, addressDsp} < 9'(CELLS)));
    assign wr_addr_s   = sweeping_s ? BAW'(sweep_cnt_r) : BAW'(addressDsp);
    assign wr_data_s   = sweeping_s ? 8'h20 : dataDsp;
    assign rd_addr_s   = 9'(row_r) * 9'(COLS) + 9'(col_r);
    assign auto_hit_s  = (AUTO_TICKS > 0) && (state_r == ST_IDLE) && tick_s &&
                         (auto_cnt_r == AUW'(AUTO_LAST));
    assign req_s       = update | pending_r | auto_hit_s;
    assign cmd_state_s = (state_r == ST_INIT) || (state_r == ST_ROWADDR) || (state_r == ST_CHARS);

    // Buffer storage: one write port, registered read port (not reset).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        rd_data_r <= mem_r[BAW'(rd_addr_s)];
    end

    // Byte to put on the bus at the next SETUP tick and the low time that follows.
    always_comb begin
        case (row_r)
            2'd0:    base_s = 8'h00;
            2'd1:    base_s = 8'h40;
            2'd2:    base_s = BASE2;
            default: base_s = BASE3;
        endcase
        case (state_r)
            ST_INIT: begin
                case (init_idx_r)
                    2'd0:    cmd_byte_s = 8'h38;
                    2'd1:    cmd_byte_s = 8'h0C;
                    2'd2:    cmd_byte_s = 8'h01;
                    default: cmd_byte_s = 8'h06;
                endcase
            end
            ST_ROWADDR: cmd_byte_s = 8'h80 | base_s;
            ST_CHARS:   cmd_byte_s = rd_data_r;
            default:    cmd_byte_s = 8'h00;
        endcase
        if (!lcd_rs_r && lcd_data_r == 8'h01) begin
            wait_last_s = 16'(CLEAR_TICKS - 1);
        end else begin
            wait_last_s = 16'(CMD_TICKS - 1);
        end
    end

    // Next-state logic: bus phase engine plus sequencer.
    always_comb begin
        state_n     = state_r;
        phase_n     = phase_r;
        wait_n      = wait_cnt_r;
        init_idx_n  = init_idx_r;
        row_n       = row_r;
        col_n       = col_r;
        busy_n      = busy_r;
        init_done_n = init_done_r;
        rs_n        = lcd_rs_r;
        e_n         = lcd_e_r;
        data_n      = lcd_data_r;
        pending_n   = pending_r | (busy_r & update);
        auto_n      = {AUW{1'b0}};

        if (cmd_state_s && tick_s) begin
            case (phase_r)
                PH_SETUP: begin
                    rs_n    = (state_r == ST_CHARS);
                    data_n  = cmd_byte_s;
                    e_n     = 1'b0;
                    phase_n = PH_STROBE;
                end
                PH_STROBE: begin
                    e_n     = 1'b1;
                    phase_n = PH_WAIT;
                    wait_n  = 16'd0;
                end
                default: begin
                    e_n = 1'b0;
                    if (wait_cnt_r == wait_last_s) begin
                        phase_n = PH_SETUP;
                    end else begin
                        wait_n = wait_cnt_r + 16'd1;
                    end
                end
            endcase
        end else begin
            phase_n = phase_n;
        end

        // A transfer completes on the last low tick of its wait.
        case (state_r)
            ST_POWER: begin
                if (tick_s) begin
                    if (wait_cnt_r == 16'(POWER_TICKS - 1)) begin
                        state_n    = ST_INIT;
                        phase_n    = PH_SETUP;
                        wait_n     = 16'd0;
                        init_idx_n = 2'd0;
                    end else begin
                        wait_n = wait_cnt_r + 16'd1;
                    end
                end else begin
                    wait_n = wait_cnt_r;
                end
            end
            ST_INIT: begin
                if (tick_s && phase_r == PH_WAIT && wait_cnt_r == wait_last_s) begin
                    if (init_idx_r == 2'd3) begin
                        state_n     = ST_IDLE;
                        init_done_n = 1'b1;
                        busy_n      = 1'b0;
                    end else begin
                        init_idx_n = init_idx_r + 2'd1;
                    end
                end else begin
                    init_idx_n = init_idx_r;
                end
            end
            ST_IDLE: begin
                auto_n = auto_cnt_r + AUW'(tick_s);
                if (req_s) begin
                    state_n   = ST_ROWADDR;
                    phase_n   = PH_SETUP;
                    busy_n    = 1'b1;
                    pending_n = 1'b0;
                    row_n     = 2'd0;
                    auto_n    = {AUW{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ROWADDR: begin
                if (tick_s && phase_r == PH_WAIT && wait_cnt_r == wait_last_s) begin
                    state_n = ST_CHARS;
                    col_n   = 6'd0;
                end else begin
                    col_n = col_r;
                end
            end
            ST_CHARS: begin
                if (tick_s && phase_r == PH_WAIT && wait_cnt_r == wait_last_s) begin
                    if (col_r != 6'(COLS - 1)) begin
                        col_n = col_r + 6'd1;
                    end else if (row_r != 2'(ROWS - 1)) begin
                        row_n   = row_r + 2'd1;
                        state_n = ST_ROWADDR;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    col_n = col_r;
                end
            end
            default: begin
                state_n = ST_POWER;
                phase_n = PH_SETUP;
                wait_n  = 16'd0;
            end
        endcase
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            state_r     <= ST_POWER;
            phase_r     <= PH_SETUP;
            wait_cnt_r  <= 16'd0;
            init_idx_r  <= 2'd0;
            row_r       <= 2'd0;
            col_r       <= 6'd0;
            auto_cnt_r  <= {AUW{1'b0}};
            div_cnt_r   <= {DW{1'b0}};
            sweep_cnt_r <= 9'd0;
            pending_r   <= 1'b0;
            busy_r      <= 1'b1;
            init_done_r <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_e_r     <= 1'b0;
            lcd_data_r  <= 8'h00;
        end else begin
            state_r     <= state_n;
            phase_r     <= phase_n;
            wait_cnt_r  <= wait_n;
            init_idx_r  <= init_idx_n;
            row_r       <= row_n;
            col_r       <= col_n;
            auto_cnt_r  <= auto_n;
            div_cnt_r   <= tick_s ? {DW{1'b0}} : div_cnt_r + DW'(1);
            sweep_cnt_r <= sweeping_s ? sweep_cnt_r + 9'd1 : sweep_cnt_r;
            pending_r   <= pending_n;
            busy_r      <= busy_n;
            init_done_r <= init_done_n;
            lcd_rs_r    <= rs_n;
            lcd_e_r     <= e_n;
            lcd_data_r  <= data_n;
        end
    end

    assign lcd_rs    = lcd_rs_r;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_r;
    assign lcd_data  = lcd_data_r;
    assign busy      = busy_r;
    assign init_done = init_done_r;
endmodule

// File: tb/tb_lcd_text_engine.sv
// Scoreboard bench: a 2x16 instance checked strobe-by-strobe against a buffer
// model, plus a 4x20 auto-refresh instance checked for row order and interval.
module tb_lcd_text_engine;
    localparam int DIV = 4, PWR = 10, CMD = 2, CLR = 5;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       idone;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sysrst, update, wren;
    logic [7:0] addr, din;
    logic       lcd_rs, lcd_rw, lcd_e, busy, init_done;
    logic [7:0] lcd_data;

    logic       sysrst_b, update_b, wren_b;
    logic [7:0] addr_b, din_b;
    logic       lcd_rs_b, lcd_rw_b, lcd_e_b, busy_b, init_done_b;
    logic [7:0] lcd_data_b;

    exp_t        sb[$];
    logic [7:0]  model_buf [32];
    int          n_checks = 0, n_fail = 0, cyc = 0;
    bit          b_done = 1'b0;

    lcd_text_engine #(.CLK_DIV(DIV), .ROWS(2), .COLS(16), .POWER_TICKS(PWR),
                      .CMD_TICKS(CMD), .CLEAR_TICKS(CLR), .AUTO_TICKS(0)) dut (
        .clk(clk), .sysrst(sysrst), .update(update), .wren(wren),
        .addressDsp(addr), .dataDsp(din), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy), .init_done(init_done));

    lcd_text_engine #(.CLK_DIV(DIV), .ROWS(4), .COLS(20), .POWER_TICKS(PWR),
                      .CMD_TICKS(CMD), .CLEAR_TICKS(CLR), .AUTO_TICKS(50)) dut_b (
        .clk(clk), .sysrst(sysrst_b), .update(update_b), .wren(wren_b),
        .addressDsp(addr_b), .dataDsp(din_b), .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b),
        .lcd_e(lcd_e_b), .lcd_data(lcd_data_b), .busy(busy_b), .init_done(init_done_b));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d, input logic idn, input int gap);
        exp_t x;
        x.rs = rs; x.data = d; x.idone = idn; x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 1'b0, 0);
        push(1'b0, 8'h0C, 1'b0, (CMD + 2) * DIV);
        push(1'b0, 8'h01, 1'b0, (CMD + 2) * DIV);
        push(1'b0, 8'h06, 1'b0, (CLR + 2) * DIV);
    endtask

    // One refresh as the display should see it: row command, then 16 live characters.
    task automatic push_frame();
        logic [7:0] row_cmd [2];
        row_cmd[0] = 8'h80;
        row_cmd[1] = 8'hC0;
        for (int r = 0; r < 2; r++) begin
            push(1'b0, row_cmd[r], 1'b1, (r == 0) ? 0 : (CMD + 2) * DIV);
            for (int c = 0; c < 16; c++) begin
                push(1'b1, model_buf[r * 16 + c], 1'b1, (CMD + 2) * DIV);
            end
        end
    endtask

    task automatic write_cell(input int a, input int d);
        @(negedge clk);
        wren = 1'b1; addr = 8'(a); din = 8'(d);
        if (a < 32) model_buf[a] = 8'(d);
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_init();
        int t = 0;
        while (!init_done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("init_done_rise", int'(init_done), 1);
        chk("busy_after_init", int'(busy), 0);
        chk("init_strobes_left", sb.size(), 0);
    endtask

    task automatic wait_idle();
        int t = 0, quiet = 0;
        while (quiet < 4 * DIV && t < 20000) begin
            @(negedge clk);
            t++;
            if (!busy && sb.size() == 0) quiet++;
            else quiet = 0;
        end
        chk("idle_reached", int'(quiet >= 4 * DIV), 1);
    endtask

    // Monitor for the 2x16 instance: every rising strobe pops one expectation.
    initial begin
        logic prev_e = 1'b0;
        int   last_rise = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!sysrst && lcd_e && !prev_e) begin
                chk("strobe_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk("rs", int'(lcd_rs), int'(x.rs));
                    chk("data", int'(lcd_data), int'(x.data));
                    chk("init_done_at_strobe", int'(init_done), int'(x.idone));
                    chk("busy_at_strobe", int'(busy), 1);
                    chk("rw", int'(lcd_rw), 0);
                    if (x.gap != 0) chk("strobe_gap", cyc - last_rise, x.gap);
                end
                last_rise = cyc;
            end
            prev_e = sysrst ? 1'b0 : lcd_e;
        end
    end

    // 4x20 instance: row-command order and auto-refresh spacing.
    initial begin
        int row_exp [4];
        int rows_seen = 0, intervals = 0, fall_cyc = 0, t = 0;
        bit have_fall = 1'b0;
        logic pe = 1'b0, pb = 1'b1;
        row_exp[0] = 32'h80; row_exp[1] = 32'hC0; row_exp[2] = 32'h94; row_exp[3] = 32'hD4;
        @(negedge clk);
        while (sysrst_b) @(negedge clk);
        while (!(rows_seen >= 8 && intervals >= 2) && t < 30000) begin
            @(negedge clk);
            t++;
            if (lcd_e_b && !pe && !lcd_rs_b && init_done_b) begin
                chk("row_cmd_4x20", int'(lcd_data_b), row_exp[rows_seen % 4]);
                rows_seen++;
            end
            if (init_done_b && pb && !busy_b) begin
                fall_cyc = cyc;
                have_fall = 1'b1;
            end
            if (init_done_b && !pb && busy_b && have_fall) begin
                chk("auto_interval", cyc - fall_cyc, 50 * DIV);
                intervals++;
            end
            pe = lcd_e_b;
            pb = busy_b;
        end
        chk("auto_progress", int'(rows_seen >= 8 && intervals >= 2), 1);
        b_done = 1'b1;
    end

    initial begin
        int hi = 0, t = 0;
        sysrst = 1'b1; sysrst_b = 1'b1;
        update = 1'b0; wren = 1'b0; addr = 8'h00; din = 8'h00;
        update_b = 1'b0; wren_b = 1'b0; addr_b = 8'h00; din_b = 8'h00;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        push_init();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 1);
        chk("reset_init_done", int'(init_done), 0);
        chk("reset_data", int'(lcd_data), 0);
        sysrst = 1'b0; sysrst_b = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (lcd_e) hi++;
        end
        chk("e_quiet_power", hi, 0);
        wait_init();

        write_cell(0, 8'h48);
        write_cell(17, 8'h69);
        write_cell(32, 8'h41);
        write_cell(255, 8'h55);
        pulse_update();
        push_frame();
        wait_idle();

        // Three requests during one refresh merge into a single follow-up.
        pulse_update();
        push_frame();
        repeat (30) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("busy_during_req", int'(busy), 1);
            pulse_update();
            repeat (50) @(negedge clk);
        end
        push_frame();
        wait_idle();

        for (int k = 0; k < 5; k++) begin
            int n = $urandom_range(1, 6);
            for (int w = 0; w < n; w++) begin
                write_cell($urandom_range(0, 47), $urandom_range(0, 255));
            end
            pulse_update();
            push_frame();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(20, 200)) @(negedge clk);
                pulse_update();
                push_frame();
            end
            wait_idle();
        end

        // Reset in the middle of a strobe.
        pulse_update();
        push_frame();
        repeat (100) @(negedge clk);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!lcd_e && t < 5000);
        chk("e_high_before_reset", int'(lcd_e), 1);
        #1 sysrst = 1'b1;
        #1;
        chk("rst_lcd_e", int'(lcd_e), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        sb.delete();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        push_init();
        repeat (2) @(negedge clk);
        sysrst = 1'b0;
        wait_init();
        pulse_update();
        push_frame();
        wait_idle();

        t = 0;
        while (!b_done && t < 40000) begin
            @(negedge clk);
            t++;
        end
        chk("auto_block_finished", int'(b_done), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_text_engine.md
Name: lcd_text_engine

Overview:
- Parametrised successor of the single-size character-LCD front end: an HD44780-compatible 8-bit-bus text engine for 1-4 rows of any column count.
- Owns the character buffer, the DSP-side write port, the bus-timing tick divider, the power-on init sequence and a row-addressed refresh sequencer in one clock domain.
- Adds three behaviours: busy/init_done status, one queued update request, and an optional periodic auto-refresh.

Parameters:
- CLK_DIV, 16, clk cycles per bus tick; minimum 2.
- ROWS, 2, display rows, 1..4.
- COLS, 16, characters per row, 1..40; ROWS*COLS must be 256 or less.
- POWER_TICKS, 4000, ticks to wait after reset before the first command.
- CMD_TICKS, 16, low ticks after each ordinary command or data strobe.
- CLEAR_TICKS, 600, low ticks after the clear (0x01) command.
- AUTO_TICKS, 0, ticks between self-triggered refreshes; 0 disables auto-refresh.

Ports:
- clk  in  1  system clock.
- sysrst  in  1  reset; asynchronous, active-high.
- update  in  1  refresh request; sampled every clk cycle.
- wren  in  1  buffer write enable.
- addressDsp  in  8  buffer address, linear index = row*COLS + col.
- dataDsp  in  8  character code to write.
- lcd_rs  out  1  register select (0 = command, 1 = data).
- lcd_rw  out  1  read/write; always 0.
- lcd_e  out  1  enable strobe.
- lcd_data  out  8  LCD data bus.
- busy  out  1  high while init or refresh is in progress.
- init_done  out  1  high once the init sequence has completed; stays high.

Behaviour:
- Reset values: lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=0x00, busy=1, init_done=0. Tick counter=0, pending=0, FSM=POWER.
- Tick: a one-clk pulse every CLK_DIV clk cycles, free-running from reset. All LCD output changes occur only on tick cycles.
- Buffer: ROWS*COLS bytes, one write port and one read port, registered read with 1-clk latency.
- Buffer fill: for the first ROWS*COLS clk cycles after reset, a sweep writes 0x20 to every cell. wren is ignored during the sweep.
- Buffer writes: after the sweep, wren=1 with addressDsp < ROWS*COLS writes dataDsp in the same cycle. Out-of-range addresses are dropped silently. Writes are accepted in every FSM state.
- Bus transaction: 1 SETUP tick (rs/data driven, e=0), then 1 tick with e=1, then e=0 for CMD_TICKS ticks, or CLEAR_TICKS ticks for 0x01. rs and data are held from SETUP until the next SETUP.
- FSM states: POWER -> INIT -> IDLE -> ROWADDR -> CHARS -> (ROWADDR | IDLE).
  - POWER: wait POWER_TICKS ticks.
  - INIT: send, in order, commands 0x38, 0x0C, 0x01, 0x06. On completion: init_done=1, busy=0, go to IDLE.
  - IDLE: a request is update=1, pending=1, or an auto-refresh expiry. Any request sets busy=1, clears pending, sets row=0 and goes to ROWADDR.
  - ROWADDR: send command 0x80|base(row), with base = {0x00, 0x40, COLS, 0x40+COLS}[row].
  - CHARS: send COLS data strobes (rs=1) with the buffer contents of row, col 0..COLS-1. Each character is read from the buffer at its own SETUP tick, so it is live, not snapshotted.
  - After the last column: if row < ROWS-1, increment row and return to ROWADDR; otherwise busy=0 and go to IDLE.
- update=1 on any cycle while busy=1 (including POWER and INIT) sets pending=1. Multiple requests merge into one. pending is served immediately on reaching IDLE.
- Auto-refresh: when AUTO_TICKS>0, a tick counter runs only in IDLE, resets on leaving IDLE, and raises a request when it reaches AUTO_TICKS.
- update and auto expiry in the same cycle produce one refresh.
- A buffer write to a cell already sent this refresh appears on the next refresh.
- sysrst asserted at any point, including mid-strobe: outputs return to reset values immediately; init and sweep restart; pending is lost.

Test Plan:
- Reset, CLK_DIV=4, POWER_TICKS=10, CMD_TICKS=2, CLEAR_TICKS=5 -> lcd_e stays 0 for 40 clk; then four e pulses with lcd_data 0x38, 0x0C, 0x01, 0x06 and rs=0; gap after 0x01 is 5 ticks; init_done rises after the last wait; busy falls with it.
- After init, write 'H'(0x48) at address 0 and 'i'(0x69) at address 17 (ROWS=2, COLS=16), then pulse update -> command 0x80, data 0x48 then 15×0x20, command 0xC0, data 0x20, 0x69, 14×0x20; busy=1 throughout, 0 afterwards.
- update pulsed three times during a refresh -> exactly one further refresh follows; no third refresh.
- wren with addressDsp=32 on a 2x16 config, then refresh -> all cells still 0x20.
- ROWS=4, COLS=20 -> row commands 0x80, 0xC0, 0x94, 0xD4 in that order.
- AUTO_TICKS=50 with no update -> refresh starts 50 ticks after each return to IDLE.
- sysrst pulsed while lcd_e=1 mid-refresh -> lcd_e=0, busy=1, init_done=0 in the same cycle; the full init sequence replays.
